// File: rtl/menshen_axil_ctrl_regs_pkg.sv
// Shared definitions for the Menshen AXI-Lite control register block: register offsets,
// AXI response codes, CTRL bit positions and the address decoder used by both channels.
// No ports (package).
package menshen_axil_pkg;

  localparam logic [31:0] OFF_ID      = 32'h0000_0000;
  localparam logic [31:0] OFF_CTRL    = 32'h0000_1000;
  localparam logic [31:0] OFF_STATUS  = 32'h0000_1004;
  localparam logic [31:0] OFF_RX_CNT  = 32'h0000_1008;
  localparam logic [31:0] OFF_TX_CNT  = 32'h0000_100C;
  localparam logic [31:0] OFF_DROP    = 32'h0000_1010;
  localparam logic [31:0] OFF_SCRATCH = 32'h0000_1014;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned CTRL_ENABLE_BIT     = 0;
  localparam int unsigned CTRL_DROP_ALL_BIT   = 1;
  localparam int unsigned CTRL_STAT_CLEAR_BIT = 2;

  typedef enum logic [2:0] {
    RegId, RegCtrl, RegStatus, RegRx, RegTx, RegDrop, RegScratch, RegNone
  } reg_sel_e;

  // Only bits [dec_w-1:2] take part; byte-lane bits and upper bits are don't-care.
  function automatic reg_sel_e decode(input logic [31:0] addr, input int unsigned dec_w);
    logic [31:0] mask;
    reg_sel_e    sel;
    mask = ((32'd1 << dec_w) - 32'd1) & 32'hFFFF_FFFC;
    case (addr & mask)
      OFF_ID:      sel = RegId;
      OFF_CTRL:    sel = RegCtrl;
      OFF_STATUS:  sel = RegStatus;
      OFF_RX_CNT:  sel = RegRx;
      OFF_TX_CNT:  sel = RegTx;
      OFF_DROP:    sel = RegDrop;
      OFF_SCRATCH: sel = RegScratch;
      default:     sel = RegNone;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/menshen_axil_ctrl_regs_if.sv
// AXI4-Lite bus bundle (no wstrb, no prot). master drives valid/addr/data/ready-for-response,
// slave drives ready/response/read data.
interface menshen_axil_ctrl_regs_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              awvalid;
  logic [ADDR_W-1:0] awaddr;
  logic              awready;
  logic              wvalid;
  logic [31:0]       wdata;
  logic              wready;
  logic              bvalid;
  logic [1:0]        bresp;
  logic              bready;
  logic              arvalid;
  logic [ADDR_W-1:0] araddr;
  logic              arready;
  logic              rvalid;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rready;

  modport master (
    output awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/menshen_sat_counter.sv
// Saturating event counter: clk, rst_n (async active-low), inc (+1), clr (zero, wins over
// inc), cnt (current value). Holds at all-ones instead of wrapping.
module menshen_sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);
  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/menshen_axil_ctrl_regs.sv
// AXI4-Lite control/status registers for the Menshen datapath.
// Ports: axil_aclk/axil_aresetn (clock, async active-low reset); s_axil (AXI-Lite slave);
// ev_rx_pkt/ev_tx_pkt/ev_drop_pkt (event pulses feeding saturating counters);
// ctrl_enable/ctrl_drop_all (static CTRL bits); stat_clear (one-cycle counter clear pulse).
module menshen_axil_ctrl_regs
  import menshen_axil_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DEC_W    = 13,
  parameter logic [31:0] ID_VALUE = 32'h4D53_0001
) (
  input  logic                    axil_aclk,
  input  logic                    axil_aresetn,
  menshen_axil_ctrl_regs_if.slave s_axil,
  input  logic                    ev_rx_pkt,
  input  logic                    ev_tx_pkt,
  input  logic                    ev_drop_pkt,
  output logic                    ctrl_enable,
  output logic                    ctrl_drop_all,
  output logic                    stat_clear
);

  // Keeps every ready low while reset is asserted and releases them one cycle later.
  logic              live_q;
  logic              aw_held_q, w_held_q, bvalid_q;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [31:0]       w_data_q;
  logic [1:0]        bresp_q;
  logic              en_q, drop_q;
  logic [31:0]       scratch_q;
  logic              rvalid_q;
  logic [31:0]       rdata_q;
  logic [1:0]        rresp_q;
  logic [31:0]       rx_cnt, tx_cnt, drop_cnt;
  logic              wr_commit;
  reg_sel_e          wr_sel, rd_sel;
  logic [31:0]       rd_word;
  logic [1:0]        rd_resp;

  assign wr_commit = aw_held_q & w_held_q;
  assign wr_sel    = decode(32'(aw_addr_q), DEC_W);
  assign rd_sel    = decode(32'(s_axil.araddr), DEC_W);

  assign s_axil.awready = live_q & ~aw_held_q & ~bvalid_q;
  assign s_axil.wready  = live_q & ~w_held_q & ~bvalid_q;
  assign s_axil.bvalid  = bvalid_q;
  assign s_axil.bresp   = bresp_q;
  assign s_axil.arready = live_q & ~rvalid_q;
  assign s_axil.rvalid  = rvalid_q;
  assign s_axil.rdata   = rdata_q;
  assign s_axil.rresp   = rresp_q;

  assign ctrl_enable   = en_q;
  assign ctrl_drop_all = drop_q;
  assign stat_clear    = wr_commit & (wr_sel == RegCtrl) & w_data_q[CTRL_STAT_CLEAR_BIT];

  always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
    if (!axil_aresetn) begin
      live_q <= 1'b0;
    end else begin
      live_q <= 1'b1;
    end
  end

  // Write channel: AW and W are latched independently; commit once both are held.
  always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
    if (!axil_aresetn) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      en_q      <= 1'b0;
      drop_q    <= 1'b0;
      scratch_q <= '0;
    end else begin
      if (s_axil.awvalid && s_axil.awready) begin
        aw_held_q <= 1'b1;
        aw_addr_q <= s_axil.awaddr;
      end
      if (s_axil.wvalid && s_axil.wready) begin
        w_held_q <= 1'b1;
        w_data_q <= s_axil.wdata;
      end
      if (wr_commit) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= (wr_sel == RegNone) ? RESP_SLVERR : RESP_OKAY;
        case (wr_sel)
          RegCtrl: begin
            en_q   <= w_data_q[CTRL_ENABLE_BIT];
            drop_q <= w_data_q[CTRL_DROP_ALL_BIT];
          end
          RegScratch: scratch_q <= w_data_q;
          default: ;
        endcase
      end else if (bvalid_q && s_axil.bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_word = '0;
    rd_resp = RESP_OKAY;
    case (rd_sel)
      RegId:              rd_word = ID_VALUE;
      RegCtrl, RegStatus: rd_word = {30'b0, drop_q, en_q};
      RegRx:              rd_word = rx_cnt;
      RegTx:              rd_word = tx_cnt;
      RegDrop:            rd_word = drop_cnt;
      RegScratch:         rd_word = scratch_q;
      default:            rd_resp = RESP_SLVERR;
    endcase
  end

  // Read channel: sampling register state at the accept edge gives old-value semantics for
  // a write committing on that same edge.
  always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
    if (!axil_aresetn) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (s_axil.arvalid && s_axil.arready) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_word;
      rresp_q  <= rd_resp;
    end else if (rvalid_q && s_axil.rready) begin
      rvalid_q <= 1'b0;
    end
  end

  menshen_sat_counter #(.WIDTH(32)) u_rx_cnt (
    .clk(axil_aclk), .rst_n(axil_aresetn), .inc(ev_rx_pkt), .clr(stat_clear), .cnt(rx_cnt)
  );
  menshen_sat_counter #(.WIDTH(32)) u_tx_cnt (
    .clk(axil_aclk), .rst_n(axil_aresetn), .inc(ev_tx_pkt), .clr(stat_clear), .cnt(tx_cnt)
  );
  menshen_sat_counter #(.WIDTH(32)) u_drop_cnt (
    .clk(axil_aclk), .rst_n(axil_aresetn), .inc(ev_drop_pkt), .clr(stat_clear),
    .cnt(drop_cnt)
  );

endmodule
